// File: rtl/led_snake_pattern_ctrl_pkg.sv
// Shared constants, FSM state type and head arithmetic for the LED snake
// frame-set scheduler.
//
// Contents:
//   NUM_LEDS / HEAD_W  : LED chain length and head index width
//   COLOR_W / CH_W     : GRB word width and per-channel width
//   DIV_W              : width of the request-count divider
//   LED_OFF            : word driven to unlit LEDs
//   state_e            : IDLE / COMPOSE / ACK scheduler states
//   step_head()        : one head move in the selected direction
//   seg_dist()         : segment index of an LED relative to the head
package led_snake_pattern_ctrl_pkg;

  localparam int NUM_LEDS = 8;
  localparam int HEAD_W   = 3;
  localparam int COLOR_W  = 24;
  localparam int CH_W     = 8;
  localparam int DIV_W    = 8;

  localparam logic [COLOR_W-1:0] LED_OFF = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPOSE = 2'd1,
    ST_ACK     = 2'd2
  } state_e;

  // The head index is exactly HEAD_W bits wide, so plain modular
  // arithmetic gives the 7->0 / 0->7 wrap for free.
  function automatic logic [HEAD_W-1:0] step_head(input logic [HEAD_W-1:0] head,
                                                  input logic              dir);
    return dir ? (head - HEAD_W'(1)) : (head + HEAD_W'(1));
  endfunction

  // Distance from the head to LED idx, measured along the tail.
  // dir=0 puts the tail at lower indices, dir=1 at higher indices.
  function automatic logic [HEAD_W-1:0] seg_dist(input logic [HEAD_W-1:0] head,
                                                 input logic [HEAD_W-1:0] idx,
                                                 input logic              dir);
    return dir ? (idx - head) : (head - idx);
  endfunction

endpackage

// File: rtl/led_snake_pattern_ctrl_if.sv
// Frame-set handshake between the WS2812 chain driver and the snake
// pattern scheduler.
//
// Signals:
//   new_frames_set_rqst : driver -> scheduler, rising edge requests a set
//   frames_set_ack      : scheduler -> driver, 1-cycle pulse, set is valid
//   led0..led7          : scheduler -> driver, 24-bit GRB words
// Modports:
//   master : driver side
//   slave  : scheduler side
interface led_snake_pattern_ctrl_if;
  import led_snake_pattern_ctrl_pkg::*;

  logic               new_frames_set_rqst;
  logic               frames_set_ack;
  logic [COLOR_W-1:0] led0;
  logic [COLOR_W-1:0] led1;
  logic [COLOR_W-1:0] led2;
  logic [COLOR_W-1:0] led3;
  logic [COLOR_W-1:0] led4;
  logic [COLOR_W-1:0] led5;
  logic [COLOR_W-1:0] led6;
  logic [COLOR_W-1:0] led7;

  modport master (
    output new_frames_set_rqst,
    input  frames_set_ack,
    input  led0, led1, led2, led3, led4, led5, led6, led7
  );

  modport slave (
    input  new_frames_set_rqst,
    output frames_set_ack,
    output led0, led1, led2, led3, led4, led5, led6, led7
  );

endinterface

// File: rtl/led_snake_pattern_ctrl_segment_color.sv
// Colour of one snake segment: combinational (color, k) -> 24-bit word.
//
// Build option: SNAKE_FADE_EN
//   defined     : each 8-bit channel of color is shifted right by k
//   not defined : every segment carries color unmodified
//
// Ports:
//   color_i : GRB colour of the head segment
//   k_i     : segment index, 0 = head
//   word_o  : GRB word for this segment
module led_snake_pattern_ctrl_segment_color
  import led_snake_pattern_ctrl_pkg::*;
(
  input  logic [COLOR_W-1:0] color_i,
  input  logic [HEAD_W-1:0]  k_i,
  output logic [COLOR_W-1:0] word_o
);

`ifdef SNAKE_FADE_EN
  // Logical shift per channel; k never exceeds 7 so a channel never
  // needs more than the 8-bit shifter.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0]   ch,
                                              input logic [HEAD_W-1:0] k);
    return ch >> k;
  endfunction

  assign word_o = {fade_ch(color_i[23:16], k_i),
                   fade_ch(color_i[15:8],  k_i),
                   fade_ch(color_i[7:0],   k_i)};
`else
  logic unused_k;

  assign unused_k = ^k_i;
  assign word_o   = color_i;
`endif

endmodule

// File: rtl/led_snake_pattern_ctrl.sv
// Frame-set scheduler for the 8-LED WS2812 chain driver. Each rising edge
// of the driver's request composes a new set of eight GRB words forming a
// moving snake of configurable colour, length, direction and speed, then
// pulses frames_set_ack for one cycle.
//
// Build option: SNAKE_FADE_EN (tail fade, see segment_color sub-module).
//
// Ports:
//   clk          : system clock, single domain
//   rstn         : synchronous active-low reset
//   bus          : slave side of the driver handshake (rqst, ack, led0..7)
//   enable       : 1 = draw snake, 0 = all LEDs off (request still acked)
//   dir          : 0 = head moves 0->7, 1 = head moves 7->0
//   step_div     : head advances once per step_div+1 requests
//   snake_len    : snake length is snake_len+1 LEDs
//   color        : GRB colour of the head segment
//   head_pos_dbg : current head index
module led_snake_pattern_ctrl
  import led_snake_pattern_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  led_snake_pattern_ctrl_if.slave  bus,
  input  logic                     enable,
  input  logic                     dir,
  input  logic [DIV_W-1:0]         step_div,
  input  logic [HEAD_W-1:0]        snake_len,
  input  logic [COLOR_W-1:0]       color,
  output logic [HEAD_W-1:0]        head_pos_dbg
);

  state_e             state_q;
  logic               rqst_q;
  logic               pending_q;
  logic               ack_q;
  logic [HEAD_W-1:0]  head_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [COLOR_W-1:0] led_q [NUM_LEDS];

  logic               req_edge;
  logic [HEAD_W-1:0]  head_d;
  logic [DIV_W-1:0]   cnt_d;
  logic [HEAD_W-1:0]  seg_k  [NUM_LEDS];
  logic [COLOR_W-1:0] seg_w  [NUM_LEDS];
  logic [COLOR_W-1:0] led_d  [NUM_LEDS];

  assign req_edge = bus.new_frames_set_rqst & ~rqst_q;

  // Divider and head update; only committed in COMPOSE.
  always_comb begin
    head_d = head_q;
    cnt_d  = cnt_q;
    if (enable) begin
      if (cnt_q == step_div) begin
        cnt_d  = '0;
        head_d = step_head(head_q, dir);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Each LED works out which segment it would be from the new head; it is
  // lit only when that segment index lies within the snake.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    assign seg_k[i] = seg_dist(head_d, HEAD_W'(i), dir);

    led_snake_pattern_ctrl_segment_color u_seg (
      .color_i (color),
      .k_i     (seg_k[i]),
      .word_o  (seg_w[i])
    );

    assign led_d[i] = (enable && (seg_k[i] <= snake_len)) ? seg_w[i] : LED_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rqst_q    <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      head_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_q[i] <= LED_OFF;
      end
    end else begin
      rqst_q <= bus.new_frames_set_rqst;
      ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A pending request and a fresh edge in the same cycle are
          // served by a single frame set.
          if (req_edge || pending_q) begin
            state_q   <= ST_COMPOSE;
            pending_q <= 1'b0;
          end
        end
        ST_COMPOSE: begin
          if (req_edge) begin
            pending_q <= 1'b1;
          end
          head_q <= head_d;
          cnt_q  <= cnt_d;
          for (int i = 0; i < NUM_LEDS; i++) begin
            led_q[i] <= led_d[i];
          end
          // Ack is registered here so it rises together with the new words.
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (req_edge) begin
            pending_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.frames_set_ack = ack_q;
  assign bus.led0           = led_q[0];
  assign bus.led1           = led_q[1];
  assign bus.led2           = led_q[2];
  assign bus.led3           = led_q[3];
  assign bus.led4           = led_q[4];
  assign bus.led5           = led_q[5];
  assign bus.led6           = led_q[6];
  assign bus.led7           = led_q[7];
  assign head_pos_dbg       = head_q;

endmodule
